// File: rtl/uart_rx_pkg.sv
// Shared types and timing offsets for the oversampling UART receiver.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  // Offsets relative to P/2 within one bit cell.
  localparam int SMP_OFS_EARLY = -1;
  localparam int SMP_OFS_MID   = 0;
  localparam int SMP_OFS_LATE  = 1;
  localparam int DECIDE_OFS    = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-cell timer plus three-point majority sampler around the cell centre.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable_i,
  input  logic                  rx_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_done_o,
  output logic                  sample_ready_o,
  output logic                  sampled_bit_o
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] half, last;
  logic [2:0]            smp_q, smp_d;

  assign half = prescale_i >> 1;
  assign last = prescale_i - PRESCALE_W'(1);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    smp_d      = smp_q;
    if (!enable_i || edge_cnt_q == last) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
    if (enable_i) begin
      if (edge_cnt_q == half + PRESCALE_W'(SMP_OFS_EARLY)) smp_d[0] = rx_i;
      if (edge_cnt_q == half + PRESCALE_W'(SMP_OFS_MID))   smp_d[1] = rx_i;
      if (edge_cnt_q == half + PRESCALE_W'(SMP_OFS_LATE))  smp_d[2] = rx_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt_q <= '0;
      smp_q      <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

  assign bit_done_o     = enable_i && (edge_cnt_q == last);
  assign sample_ready_o = enable_i && (edge_cnt_q == half + PRESCALE_W'(DECIDE_OFS));
  assign sampled_bit_o  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deframes one character, checks parity/stop, strobes the byte out.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error
);

  localparam int BW = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  par_bad_q, par_bad_d;
  logic                  dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q, par_typ_q;
  logic                  cfg_load;
  logic                  bit_done, sample_ready, sampled_bit;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK            (CLK),
    .RST            (RST),
    .enable_i       (state_q != IDLE),
    .rx_i           (RX_IN),
    .prescale_i     (prescale_q),
    .bit_done_o     (bit_done),
    .sample_ready_o (sample_ready),
    .sampled_bit_o  (sampled_bit)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    par_bad_d = par_bad_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
    cfg_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d   = START;
          cfg_load  = 1'b1;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (sample_ready && sampled_bit) state_d = IDLE;
        else if (bit_done)               state_d = DATA;
      end
      DATA: begin
        if (sample_ready) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        if (bit_done) begin
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (sample_ready && (sampled_bit != ((^shift_q) ^ par_typ_q))) par_bad_d = 1'b1;
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        // Leave at the decision point so a start bit right at the stop-bit end is seen.
        if (sample_ready) begin
          dv_d    = sampled_bit && !par_bad_q;
          pe_d    = par_bad_q;
          fe_d    = !sampled_bit;
          if (sampled_bit && !par_bad_q) pdata_d = shift_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pdata_q    <= '0;
      par_bad_q  <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      prescale_q <= PRESCALE_W'(8);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      par_bad_q <= par_bad_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      if (cfg_load) begin
        prescale_q <= Prescale;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
      end
    end
  end

  assign P_DATA        = pdata_q;
  assign data_valid    = dv_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected strobes queued per frame, popped by a strobe monitor.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid, parity_error, framing_error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] flags;   // {data_valid, parity_error, framing_error}
    logic [7:0] pdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_pdata;

  uart_rx dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .Prescale      (Prescale),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .P_DATA        (P_DATA),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    exp_t e;
    if (data_valid || parity_error || framing_error) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got dv/pe/fe=%b%b%b want none at %0t",
                 data_valid, parity_error, framing_error, $time);
      end else begin
        e = exp_q.pop_front();
        if ({data_valid, parity_error, framing_error} !== e.flags) begin
          failures++;
          $display("FAIL strobe_flags got dv/pe/fe=%b%b%b want %b at %0t",
                   data_valid, parity_error, framing_error, e.flags, $time);
        end
        checks++;
        if (P_DATA !== e.pdata) begin
          failures++;
          $display("FAIL strobe_pdata got %02h want %02h at %0t", P_DATA, e.pdata, $time);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] flags, input logic [7:0] pdata);
    exp_t e;
    e.flags = flags;
    e.pdata = pdata;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v, input int p);
    RX_IN = v;
    repeat (p) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic stop);
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(stop, p);
    RX_IN = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge CLK);
    repeat (40) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (P_DATA !== 8'h00) begin failures++; $display("FAIL reset_pdata got %02h want 00", P_DATA); end
    checks++;
    if ({data_valid, parity_error, framing_error} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes got %b%b%b want 000", data_valid, parity_error, framing_error);
    end
    model_pdata = 8'h00;
  endtask

  task automatic test_basic();
    model_pdata = 8'hA5;
    push_exp(3'b100, model_pdata);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing got %0d pending want 0", exp_q.size()); end
    checks++;
    if (P_DATA !== 8'hA5) begin failures++; $display("FAIL basic_pdata got %02h want a5", P_DATA); end
  endtask

  task automatic test_parity();
    model_pdata = 8'h3C;
    push_exp(3'b100, model_pdata);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    push_exp(3'b010, model_pdata);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL parity_missing got %0d pending want 0", exp_q.size()); end
    checks++;
    if (P_DATA !== 8'h3C) begin failures++; $display("FAIL parity_hold got %02h want 3c", P_DATA); end
    model_pdata = 8'h07;
    push_exp(3'b100, model_pdata);
    send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    checks++;
    if (P_DATA !== 8'h07) begin failures++; $display("FAIL parity_odd got %02h want 07", P_DATA); end
  endtask

  task automatic test_framing();
    push_exp(3'b001, model_pdata);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL framing_missing got %0d pending want 0", exp_q.size()); end
    checks++;
    if (P_DATA !== model_pdata) begin failures++; $display("FAIL framing_hold got %02h want %02h", P_DATA, model_pdata); end
  endtask

  task automatic test_glitch();
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (30) @(negedge CLK);
    checks++;
    if (P_DATA !== model_pdata) begin failures++; $display("FAIL glitch_hold got %02h want %02h", P_DATA, model_pdata); end
    model_pdata = 8'h5A;
    push_exp(3'b100, model_pdata);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    checks++;
    if (P_DATA !== 8'h5A) begin failures++; $display("FAIL glitch_next got %02h want 5a", P_DATA); end
  endtask

  task automatic test_back_to_back();
    push_exp(3'b100, 8'h55);
    push_exp(3'b100, 8'hAA);
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    model_pdata = 8'hAA;
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got %0d pending want 0", exp_q.size()); end
    checks++;
    if (P_DATA !== 8'hAA) begin failures++; $display("FAIL b2b_pdata got %02h want aa", P_DATA); end
  endtask

  task automatic test_reset_mid_frame();
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 24);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive_bit(1'b1, 48);
    repeat (20) @(negedge CLK);
    model_pdata = 8'h00;
    checks++;
    if (P_DATA !== 8'h00) begin failures++; $display("FAIL midreset_pdata got %02h want 00", P_DATA); end
    model_pdata = 8'h12;
    push_exp(3'b100, model_pdata);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_missing got %0d pending want 0", exp_q.size()); end
    checks++;
    if (P_DATA !== 8'h12) begin failures++; $display("FAIL midreset_next got %02h want 12", P_DATA); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
